// File: rtl/wb_design_ctrl_pkg.sv
// Shared constants, field positions and responder state type for wb_design_ctrl.
// Also holds the byte-enable merge helper used by the register write path.
package wb_design_ctrl_pkg;

  localparam logic [7:0] CTRL_OFS    = 8'h00;
  localparam logic [7:0] STATUS_OFS  = 8'h04;
  localparam logic [7:0] GPIO_LO_OFS = 8'h08;
  localparam logic [7:0] GPIO_HI_OFS = 8'h0C;
  localparam logic [7:0] SCRATCH_OFS = 8'h10;

  localparam int CTRL_OVR_EN_BIT   = 0;
  localparam int CTRL_OVR_SEL_LSB  = 4;
  localparam int CTRL_SOFT_RST_BIT = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } resp_state_e;

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_design_ctrl_sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-high reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage1_r;

  // Two back-to-back capture stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_r <= {W{1'b0}};
      q        <= {W{1'b0}};
    end else begin
      stage1_r <= d;
      q        <= stage1_r;
    end
  end

endmodule

// File: rtl/wb_design_ctrl.sv
// Wishbone classic responder controlling student design selection, with a timed
// self-clearing design reset on every selection change or firmware request.
module wb_design_ctrl
  import wb_design_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          RST_CYCLES = 16,
  parameter int          GPIO_W     = 34
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [3:0]        pad_select_i,
  input  logic [GPIO_W-1:0] gpio_in_i,
  output logic [3:0]        design_select_o,
  output logic              design_rst_o
);

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

  logic [3:0]        pad_sync_s;
  logic [GPIO_W-1:0] gpio_sync_s;
  logic [63:0]       gpio_ext_s;

  resp_state_e state_r, state_next_s;
  logic        access_s;
  logic        hit_s;
  logic        wr_s;
  logic [7:0]  ofs_s;
  logic [31:0] ctrl_cur_s;
  logic [31:0] ctrl_new_s;
  logic [31:0] rdata_s;
  logic        soft_rst_s;
  logic        sel_change_s;
  logic [3:0]  eff_sel_s;

  logic        ovr_en_r;
  logic [3:0]  ovr_sel_r;
  logic [31:0] scratch_r;
  logic [31:0] dat_r;
  logic [7:0]  rcnt_r;
  logic [3:0]  sel_r;

  sync2 #(.W(4)) u_pad_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (pad_select_i),
    .q   (pad_sync_s)
  );

  sync2 #(.W(GPIO_W)) u_gpio_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (gpio_in_i),
    .q   (gpio_sync_s)
  );

  assign gpio_ext_s = 64'(gpio_sync_s);

  // Responder state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an access is performed only on the IDLE->ACK transition.
  always_comb begin
    state_next_s = state_r;
    access_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (wbs_stb_i && wbs_cyc_i) begin
          access_s     = 1'b1;
          state_next_s = ACK;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Address decode, write qualification and read mux.
  always_comb begin
    hit_s        = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    ofs_s        = {wbs_adr_i[7:2], 2'b00};
    wr_s         = access_s && wbs_we_i && hit_s;
    ctrl_cur_s   = {23'd0, 1'b0, ovr_sel_r, 3'd0, ovr_en_r};
    ctrl_new_s   = merge_bytes(ctrl_cur_s, wbs_dat_i, wbs_sel_i);
    soft_rst_s   = wr_s && (ofs_s == CTRL_OFS) && ctrl_new_s[CTRL_SOFT_RST_BIT];
    eff_sel_s    = ovr_en_r ? ovr_sel_r : pad_sync_s;
    sel_change_s = (eff_sel_s != sel_r);
    rdata_s      = 32'd0;
    if (hit_s) begin
      case (ofs_s)
        CTRL_OFS:    rdata_s = ctrl_cur_s;
        STATUS_OFS:  rdata_s = {8'd0, rcnt_r, 7'd0, design_rst_o, pad_sync_s, eff_sel_s};
        GPIO_LO_OFS: rdata_s = gpio_ext_s[31:0];
        GPIO_HI_OFS: rdata_s = gpio_ext_s[63:32];
        SCRATCH_OFS: rdata_s = scratch_r;
        default:     rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Writable registers and the read-data holding register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ovr_en_r  <= 1'b0;
      ovr_sel_r <= 4'd0;
      scratch_r <= 32'd0;
      dat_r     <= 32'd0;
    end else begin
      if (wr_s && (ofs_s == CTRL_OFS)) begin
        ovr_en_r  <= ctrl_new_s[CTRL_OVR_EN_BIT];
        ovr_sel_r <= ctrl_new_s[CTRL_OVR_SEL_LSB +: 4];
      end
      if (wr_s && (ofs_s == SCRATCH_OFS)) begin
        scratch_r <= merge_bytes(scratch_r, wbs_dat_i, wbs_sel_i);
      end
      // Data is valid only while ACK is up; cleared on the way back to IDLE.
      if (access_s && !wbs_we_i) begin
        dat_r <= rdata_s;
      end else begin
        dat_r <= 32'd0;
      end
    end
  end

  // Effective select output and reset-pulse counter; any trigger restarts the full count.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sel_r  <= 4'd0;
      rcnt_r <= RST_LOAD;
    end else begin
      sel_r <= eff_sel_s;
      if (sel_change_s || soft_rst_s) begin
        rcnt_r <= RST_LOAD;
      end else if (rcnt_r != 8'd0) begin
        rcnt_r <= rcnt_r - 8'd1;
      end
    end
  end

  assign wbs_ack_o       = (state_r == ACK);
  assign wbs_dat_o       = dat_r;
  assign design_select_o = sel_r;
  assign design_rst_o    = (rcnt_r != 8'd0);

  logic unused_s;
  assign unused_s = ^{wbs_adr_i[1:0], ctrl_new_s[31:9], ctrl_new_s[3:1]};

endmodule

// File: doc/wb_design_ctrl.md
# wb_design_ctrl

Wishbone B4 classic-cycle responder for the management SoC's user-area bus, sitting beside the design multiplexer in the user project wrapper. Gives firmware register control over which student design is active and lets it observe the synchronized GPIO inputs. Issues a timed, self-clearing reset to the designs whenever the active selection changes or firmware requests one.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000. Slave base address; the block decodes `wbs_adr_i[31:8]`.
- `RST_CYCLES`, default 16. Length of the `design_rst_o` pulse in clocks, range 1..255.
- `GPIO_W`, default 34. Width of the GPIO input bus.

Ports:
- `wb_clk_i`  in  1  Single clock for the whole block.
- `wb_rst_i`  in  1  Reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  Byte enables.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  Address and write data.
- `wbs_ack_o`  out  1  Acknowledge.
- `wbs_dat_o`  out  32  Read data.
- `pad_select_i`  in  4  Raw design-select pads (asynchronous).
- `gpio_in_i`  in  GPIO_W  Raw GPIO inputs (asynchronous).
- `design_select_o`  out  4  Effective design select.
- `design_rst_o`  out  1  Active-high reset to the design multiplexer.

## Operation
- The pad inputs and GPIO inputs each pass through a 2-flop synchronizer.
- Register map (offset = `adr[7:2]`*4):
  - 0x00 CTRL, RW: [0] `ovr_en`, [7:4] `ovr_sel`, [8] `soft_rst`. `soft_rst` is write-1, self-clearing, and always reads 0.
  - 0x04 STATUS, RO: [3:0] effective select, [7:4] synchronized pad select, [8] `design_rst_o`, [23:16] reset counter.
  - 0x08 GPIO_LO, RO: synchronized `gpio_in[31:0]`.
  - 0x0C GPIO_HI, RO: synchronized `gpio_in[GPIO_W-1:32]`, zero-extended.
  - 0x10 SCRATCH, RW, 32 bits.
  - All other offsets, and any address outside the `BASE_ADDR[31:8]` window: writes are ignored, reads return 0, and ack is still given. The block has no err output.
- Writes honour `wbs_sel_i` per byte. Bits that are RO or unused ignore writes.
- Effective select = `ovr_en` ? `ovr_sel` : synchronized pad select. It is registered onto `design_select_o`.
- Reset counter `rcnt` (8 bits):
  - It loads `RST_CYCLES` when any of these occurs: `wb_rst_i` release, the effective select changing from its previous registered value, or a write of `soft_rst`=1.
  - Otherwise it decrements while nonzero.
  - `design_rst_o` = (`rcnt` != 0).
- Responder state machine:
  - IDLE: if `stb & cyc & !ack`, perform the access and go to ACK.
  - ACK: drive `wbs_ack_o`=1 for exactly one cycle, then return to IDLE.
  - `wbs_dat_o` holds the read data during ACK and is 0 at all other times.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `design_select_o`=0, CTRL=0, SCRATCH=0, synchronizers=0.
- While `wb_rst_i` is high, `design_rst_o`=1. `rcnt` is set to `RST_CYCLES` during reset, so `design_rst_o` stays high for `RST_CYCLES` clocks after release.
- Ack latency:
  - `stb&cyc` sampled high at edge N gives `ack`=1 after edge N+1.
  - A write takes effect at edge N+1.
  - Read data is sampled at edge N+1.
- Back-to-back accesses with strobe held high: ack toggles 1,0,1,0, so the block sustains one access per 2 cycles.
- If `stb` drops during ACK, the ack still completes. No second access is started.
- Reset asserted mid-transaction: ack is forced low immediately (asynchronous), and the access is lost.
- Pad to `design_select_o` latency: 3 clocks (2 synchronizer stages + 1 output register). `design_rst_o` rises on the same edge that `design_select_o` changes.
- Select change and `soft_rst` write on the same edge: a single load of `RST_CYCLES`.
- A reload while `rcnt` is nonzero restarts the count at `RST_CYCLES`. The pulse is extended, never shortened.
- An `ovr_en` toggle changes the select only if `ovr_sel` differs from the pad value. If it does not differ, no reset pulse is generated.

## Structure
- Package `wb_design_ctrl_pkg` holds:
  - register offset constants (`CTRL_OFS`, `STATUS_OFS`, `GPIO_LO_OFS`, `GPIO_HI_OFS`, `SCRATCH_OFS`);
  - CTRL field bit positions;
  - the responder state enum (IDLE, ACK).
- Sub-module `sync2` is a parameterized-width 2-flop synchronizer with asynchronous active-high reset. It is instantiated twice: once for the pads and once for the GPIO inputs.

## Test plan
- Reset release with `RST_CYCLES`=16: `design_rst_o` is high for exactly 16 clocks after release, then low. STATUS reads 0x0000_0000.
- Write SCRATCH 0xDEAD_BEEF with `sel`=4'b0101, then read it back: reads 0x00AD_00EF. Ack arrives exactly 1 cycle after strobe, and `wbs_dat_o`=0 outside ack.
- Pads 4'h3 → 4'h9 with `ovr_en`=0: `design_select_o` becomes 9 three clocks later, and `design_rst_o` pulses 16 clocks from that edge.
- Write CTRL=0x0000_0051: `design_select_o`=5 and a reset pulse occurs. Then write CTRL=0x0000_0100: `ovr_en` clears, the select reverts to the pad value, and a pulse occurs again. CTRL then reads 0x0000_0000.
- Drive `gpio_in`=34'h2_1234_5678 and wait 3 clocks: GPIO_LO reads 0x1234_5678 and GPIO_HI reads 0x0000_0002. A read at offset 0x40 and a read at address 0x3000_0100 both return 0 with ack.
- Assert `wb_rst_i` during a pending write to SCRATCH: no ack is issued, and SCRATCH reads 0 after release.
